cluster_cmd_tracker: RTL and testbench

- Sits directly downstream of the cluster command arbiter and upstream of the uncluster command unit.
- Takes the arbitrated command stream together with the winning core index. Allocates a command ID from a free pool and forwards the tagged command through a one-stage output register.
- Records which core owns each ID. When a completion for an ID returns, it routes a done pulse back to the issuing core and releases the ID.

---
 rtl/cluster_cmd_tracker.sv | 138 +++++++++++++
 tb/tb_cluster_cmd_tracker.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_cmd_tracker.sv
// Command ID tracker: allocates IDs from a free pool for arbitrated commands,
// records the issuing core per ID, and routes completion pulses back to it.
module cluster_cmd_tracker #(
  parameter  int NUM_CORES = 8,
  parameter  int NUM_IDS   = 16,
  parameter  int CMD_W     = 64,
  localparam int SRC_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  localparam int ID_W      = $clog2(NUM_IDS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [CMD_W-1:0]     cmd_i,
  input  logic [SRC_W-1:0]     cmd_src_i,
  output logic                 cmd_valid_o,
  input  logic                 cmd_ready_i,
  output logic [CMD_W-1:0]     cmd_o,
  output logic [ID_W-1:0]      cmd_id_o,
  input  logic                 resp_valid_i,
  input  logic [ID_W-1:0]      resp_id_i,
  output logic [NUM_CORES-1:0] done_o,
  output logic [ID_W-1:0]      done_id_o,
  output logic [ID_W:0]        outstanding_o,
  output logic                 err_o
);

  logic [NUM_IDS-1:0]   busy_q, busy_d;
  logic [SRC_W-1:0]     owner_q [NUM_IDS];
  logic [SRC_W-1:0]     owner_d [NUM_IDS];
  logic                 out_valid_q, out_valid_d;
  logic [CMD_W-1:0]     out_cmd_q, out_cmd_d;
  logic [ID_W-1:0]      out_id_q, out_id_d;
  logic [NUM_CORES-1:0] done_q, done_d;
  logic [ID_W-1:0]      done_id_q, done_id_d;
  logic [ID_W:0]        outstanding_q, outstanding_d;
  logic                 err_q, err_d;

  logic                 any_free;
  logic                 found;
  logic [ID_W-1:0]      alloc_id;
  logic                 accept;
  logic                 rel_hit;
  logic [SRC_W-1:0]     owner_sel;

  // Lowest-index free ID, chosen from busy before any same-cycle release.
  always_comb begin
    alloc_id = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NUM_IDS; i++) begin
      if (!busy_q[i] && !found) begin
        alloc_id = ID_W'(i);
        found    = 1'b1;
      end
    end
  end

  assign any_free    = ~&busy_q;
  assign cmd_ready_o = any_free && (!out_valid_q || cmd_ready_i);
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign rel_hit     = resp_valid_i && busy_q[resp_id_i];
  assign owner_sel   = owner_q[resp_id_i];

  always_comb begin
    busy_d        = busy_q;
    owner_d       = owner_q;
    out_valid_d   = out_valid_q;
    out_cmd_d     = out_cmd_q;
    out_id_d      = out_id_q;
    done_d        = '0;
    done_id_d     = '0;
    outstanding_d = outstanding_q;
    err_d         = err_q;

    if (rel_hit) begin
      busy_d[resp_id_i] = 1'b0;
      done_id_d         = resp_id_i;
    end
    // Out-of-range owners match no core, so they produce an all-zero pulse.
    for (int unsigned c = 0; c < NUM_CORES; c++) begin
      done_d[c] = rel_hit && (owner_sel == SRC_W'(c));
    end
    if (resp_valid_i && !busy_q[resp_id_i]) begin
      err_d = 1'b1;
    end

    if (accept) begin
      busy_d[alloc_id]  = 1'b1;
      owner_d[alloc_id] = cmd_src_i;
      out_valid_d       = 1'b1;
      out_cmd_d         = cmd_i;
      out_id_d          = alloc_id;
    end else if (cmd_ready_i) begin
      out_valid_d = 1'b0;
    end

    case ({accept, rel_hit})
      2'b10:   outstanding_d = outstanding_q + (ID_W+1)'(1);
      2'b01:   outstanding_d = outstanding_q - (ID_W+1)'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q        <= '0;
      for (int unsigned i = 0; i < NUM_IDS; i++) begin
        owner_q[i] <= '0;
      end
      out_valid_q   <= 1'b0;
      out_cmd_q     <= '0;
      out_id_q      <= '0;
      done_q        <= '0;
      done_id_q     <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      busy_q        <= busy_d;
      owner_q       <= owner_d;
      out_valid_q   <= out_valid_d;
      out_cmd_q     <= out_cmd_d;
      out_id_q      <= out_id_d;
      done_q        <= done_d;
      done_id_q     <= done_id_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  assign cmd_valid_o   = out_valid_q;
  assign cmd_o         = out_cmd_q;
  assign cmd_id_o      = out_id_q;
  assign done_o        = done_q;
  assign done_id_o     = done_id_q;
  assign outstanding_o = outstanding_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_cluster_cmd_tracker.sv
// Directed and randomized bench for cluster_cmd_tracker against a per-cycle
// reference model of the ID pool, owner table and output register.
module tb_cluster_cmd_tracker;
  localparam int NC = 8;
  localparam int NI = 16;
  localparam int CW = 64;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [CW-1:0] cmd_i;
  logic [2:0]    cmd_src_i;
  logic          cmd_valid_o;
  logic          cmd_ready_i;
  logic [CW-1:0] cmd_o;
  logic [3:0]    cmd_id_o;
  logic          resp_valid_i;
  logic [3:0]    resp_id_i;
  logic [NC-1:0] done_o;
  logic [3:0]    done_id_o;
  logic [4:0]    outstanding_o;
  logic          err_o;

  cluster_cmd_tracker #(.NUM_CORES(NC), .NUM_IDS(NI), .CMD_W(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_i(cmd_i), .cmd_src_i(cmd_src_i),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_o(cmd_o), .cmd_id_o(cmd_id_o),
    .resp_valid_i(resp_valid_i), .resp_id_i(resp_id_i),
    .done_o(done_o), .done_id_o(done_id_o), .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit          mbusy  [NI];
  int          mowner [NI];
  bit          mov;
  logic [63:0] mcmd;
  int          mid;
  int          mdone;
  int          mdone_id;
  bit          merr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      mbusy[i]  = 0;
      mowner[i] = 0;
    end
    mov = 0; mcmd = '0; mid = 0; mdone = 0; mdone_id = 0; merr = 0;
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < NI; i++) n += mbusy[i];
    return n;
  endfunction

  task automatic drive(input bit v, input logic [63:0] c, input int src, input bit r,
                       input bit rv, input int rid);
    cmd_valid_i  = v;
    cmd_i        = c;
    cmd_src_i    = 3'(src);
    cmd_ready_i  = r;
    resp_valid_i = rv;
    resp_id_i    = 4'(rid);
  endtask

  task automatic check_outputs();
    chk("cmd_valid_o", cmd_valid_o, mov);
    if (mov) begin
      chk("cmd_o", cmd_o, mcmd);
      chk("cmd_id_o", cmd_id_o, mid);
    end
    chk("done_o", done_o, mdone);
    if (mdone != 0) chk("done_id_o", done_id_o, mdone_id);
    chk("outstanding_o", outstanding_o, model_count());
    chk("err_o", err_o, merr);
  endtask

  // Inputs are already driven; check ready, advance model, clock, check outputs.
  task automatic cycle();
    int  a;
    bit  rdy, acc, rel;
    int  rid;
    #1;
    a = -1;
    for (int i = 0; i < NI; i++) if (!mbusy[i] && a < 0) a = i;
    rdy = (a >= 0) && (!mov || cmd_ready_i);
    chk("cmd_ready_o", cmd_ready_o, rdy);
    acc = cmd_valid_i && rdy;
    rid = int'(resp_id_i);
    rel = resp_valid_i && mbusy[rid];
    mdone = 0;
    mdone_id = 0;
    if (rel) begin
      mdone    = (mowner[rid] < NC) ? (1 << mowner[rid]) : 0;
      mdone_id = rid;
      mbusy[rid] = 0;
    end
    if (resp_valid_i && !rel) merr = 1;
    if (acc) begin
      mbusy[a]  = 1;
      mowner[a] = int'(cmd_src_i);
      mov = 1; mcmd = cmd_i; mid = a;
    end else if (cmd_ready_i) begin
      mov = 0;
    end
    @(posedge clk_i);
    #1;
    check_outputs();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, cmd_valid_o, 0);
    chk({tag, "_cmd"}, cmd_o, 0);
    chk({tag, "_id"}, cmd_id_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_done_id"}, done_id_o, 0);
    chk({tag, "_outst"}, outstanding_o, 0);
    chk({tag, "_err"}, err_o, 0);
  endtask

  initial begin
    int ord [4];
    int expd [4];
    int pick, nb;
    ord  = '{2, 0, 3, 1};
    expd = '{4, 1, 8, 2};

    rst_ni = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_all_zero("reset");
    rst_ni = 1'b1;

    // Single command
    drive(1, 64'hA5, 3, 1, 0, 0); cycle();
    chk("t1_id", cmd_id_o, 0);
    chk("t1_cmd", cmd_o, 64'hA5);
    chk("t1_outst", outstanding_o, 1);
    drive(0, 0, 0, 1, 0, 0); cycle();
    drive(0, 0, 0, 1, 1, 0); cycle();
    chk("t1_done", done_o, 8'b0000_1000);
    chk("t1_done_id", done_id_o, 0);
    drive(0, 0, 0, 1, 0, 0); cycle();
    chk("t1_done_clr", done_o, 0);
    chk("t1_outst0", outstanding_o, 0);

    // Back-pressure
    drive(1, 64'hB0, 1, 0, 0, 0); cycle();
    drive(1, 64'hB1, 2, 0, 0, 0);
    repeat (5) begin
      cycle();
      chk("bp_ready", cmd_ready_o, 0);
      chk("bp_cmd_hold", cmd_o, 64'hB0);
      chk("bp_id_hold", cmd_id_o, 0);
    end
    cmd_ready_i = 1'b1; cycle();
    chk("bp_id1", cmd_id_o, 1);
    chk("bp_cmd1", cmd_o, 64'hB1);
    drive(0, 0, 0, 1, 1, 0); cycle();
    drive(0, 0, 0, 1, 1, 1); cycle();
    drive(0, 0, 0, 1, 0, 0); cycle();

    // Pool exhaustion
    for (int i = 0; i < NI; i++) begin
      drive(1, 64'h100 + i, i % NC, 1, 0, 0); cycle();
      chk("px_id", cmd_id_o, i);
    end
    drive(1, 64'h117, 5, 1, 0, 0); cycle();
    chk("px_full_ready", cmd_ready_o, 0);
    chk("px_full_outst", outstanding_o, NI);
    drive(1, 64'h117, 5, 1, 1, 7); cycle();
    drive(1, 64'h117, 5, 1, 0, 0); cycle();
    chk("px_reuse_id", cmd_id_o, 7);
    chk("px_reuse_cmd", cmd_o, 64'h117);
    for (int i = 0; i < NI; i++) begin
      drive(0, 0, 0, 1, 1, i); cycle();
    end
    drive(0, 0, 0, 1, 0, 0); cycle();

    // Out-of-order completions
    for (int i = 0; i < 4; i++) begin
      drive(1, 64'h200 + i, i, 1, 0, 0); cycle();
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 1, ord[i]); cycle();
      chk("ooo_done", done_o, expd[i]);
      chk("ooo_done_id", done_id_o, ord[i]);
    end

    // Bogus completion
    drive(0, 0, 0, 1, 1, 5); cycle();
    chk("bogus_done", done_o, 0);
    chk("bogus_err", err_o, 1);
    chk("bogus_outst", outstanding_o, 0);
    drive(0, 0, 0, 1, 0, 0); repeat (3) cycle();
    chk("bogus_err_hold", err_o, 1);

    // Asynchronous reset with 4 IDs busy and output valid
    for (int i = 0; i < 4; i++) begin
      drive(1, 64'h300 + i, i, 1, 0, 0); cycle();
    end
    drive(0, 0, 0, 0, 0, 0);
    #2 rst_ni = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    drive(1, 64'h400, 6, 1, 0, 0); cycle();
    chk("post_rst_id", cmd_id_o, 0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      pick = int'($urandom_range(0, NI - 1));
      nb = 0;
      for (int i = 0; i < NI; i++) nb += mbusy[i];
      if (nb > 0 && $urandom_range(0, 9) < 9) begin
        while (!mbusy[pick]) pick = (pick + 1) % NI;
      end
      drive($urandom_range(0, 9) < 7, {$urandom, $urandom}, int'($urandom_range(0, NC - 1)),
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, pick);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
